// File: rtl/tx_ipv4.sv
// ---------------------------------------------------------------------------
// tx_ipv4 - IPv4 transmit framer
//
// Accepts a start request with destination IP, protocol and payload length,
// computes the IPv4 header checksum one 16-bit word per cycle, then emits a
// 20-byte option-less IPv4 header followed by the upstream payload as a
// registered byte stream.
//
// Build option: define TX_IPV4_MIN_PAD_EN to append 8'h00 pad bytes after
// payloads shorter than 26 bytes (46-byte Ethernet minimum payload). The
// header total_len / checksum always use the unpadded length.
//
// Handshake: upstream presents tx_payload with tx_payload_v; a byte is
// consumed on a rising edge where tx_payload_v=1 and tx_payload_rdy=1.
// tx_payload_v=0 while ready is an underrun: an output gap, sticky error.
//
// Ports:
//   TX_CLK, rst_n            clock, async active-low reset
//   func_en                  enable; low freezes all state and outputs
//   ip_addr, tx_dst_ip       source / destination IP (sampled at start)
//   tx_protocol              protocol field (sampled at start)
//   tx_payload_len           payload length in bytes (sampled at start)
//   tx_start, tx_busy        start request / busy status
//   tx_payload_v/_rdy, tx_payload   upstream payload byte stream
//   tx_ipv4_data_v, tx_ipv4_data    registered output byte stream
//   tx_ipv4_irq              one-cycle packet-complete pulse
//   tx_ipv4_err              sticky error (bad length or underrun)
// ---------------------------------------------------------------------------
module tx_ipv4 #(
    parameter int         OCT = 8,
    parameter logic [7:0] TTL = 8'h40,
    parameter logic [7:0] TOS = 8'h00
) (
    input  logic           TX_CLK,
    input  logic           rst_n,
    input  logic           func_en,
    input  logic [31:0]    ip_addr,
    input  logic [31:0]    tx_dst_ip,
    input  logic [7:0]     tx_protocol,
    input  logic [15:0]    tx_payload_len,
    input  logic           tx_start,
    output logic           tx_busy,
    input  logic           tx_payload_v,
    input  logic [OCT-1:0] tx_payload,
    output logic           tx_payload_rdy,
    output logic           tx_ipv4_data_v,
    output logic [OCT-1:0] tx_ipv4_data,
    output logic           tx_ipv4_irq,
    output logic           tx_ipv4_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_FOLD, S_HEADER, S_PAYLOAD, S_PAD, S_DONE
    } state_t;

`ifdef TX_IPV4_MIN_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    state_t         state_q;
    logic [31:0]    src_q, dst_q;
    logic [7:0]     proto_q;
    logic [15:0]    len_q;
    logic [15:0]    id_q;
    logic [19:0]    acc_q;
    logic [15:0]    csum_q;
    logic [3:0]     calc_idx_q;
    logic [4:0]     hdr_idx_q;
    logic [15:0]    cnt_q;
    logic           data_v_q, irq_q, err_q;
    logic [OCT-1:0] data_q;

    logic [15:0]    total_len;
    logic [15:0]    calc_word;
    logic [16:0]    fold1;
    logic [15:0]    fold2;
    logic [15:0]    csum_d;
    logic [7:0]     hdr_byte;
    logic [15:0]    cnt_d;
    logic           pad_needed;

    always_comb begin
        total_len  = len_q + 16'd20;
        cnt_d      = cnt_q + 16'd1;
        pad_needed = PAD_EN && (len_q < 16'd26);

        calc_word = 16'h0000;
        case (calc_idx_q)
            4'd0:    calc_word = {4'h4, 4'h5, TOS};
            4'd1:    calc_word = total_len;
            4'd2:    calc_word = id_q;
            4'd3:    calc_word = 16'h4000;
            4'd4:    calc_word = {TTL, proto_q};
            4'd6:    calc_word = src_q[31:16];
            4'd7:    calc_word = src_q[15:0];
            4'd8:    calc_word = dst_q[31:16];
            4'd9:    calc_word = dst_q[15:0];
            default: calc_word = 16'h0000;
        endcase

        // End-around carry: the second fold absorbs a carry produced by the first.
        fold1  = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
        fold2  = fold1[15:0] + {15'd0, fold1[16]};
        csum_d = ~fold2;

        hdr_byte = 8'h00;
        case (hdr_idx_q)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = TOS;
            5'd2:    hdr_byte = total_len[15:8];
            5'd3:    hdr_byte = total_len[7:0];
            5'd4:    hdr_byte = id_q[15:8];
            5'd5:    hdr_byte = id_q[7:0];
            5'd6:    hdr_byte = 8'h40;
            5'd8:    hdr_byte = TTL;
            5'd9:    hdr_byte = proto_q;
            5'd10:   hdr_byte = csum_q[15:8];
            5'd11:   hdr_byte = csum_q[7:0];
            5'd12:   hdr_byte = src_q[31:24];
            5'd13:   hdr_byte = src_q[23:16];
            5'd14:   hdr_byte = src_q[15:8];
            5'd15:   hdr_byte = src_q[7:0];
            5'd16:   hdr_byte = dst_q[31:24];
            5'd17:   hdr_byte = dst_q[23:16];
            5'd18:   hdr_byte = dst_q[15:8];
            5'd19:   hdr_byte = dst_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            proto_q    <= '0;
            len_q      <= '0;
            id_q       <= '0;
            acc_q      <= '0;
            csum_q     <= '0;
            calc_idx_q <= '0;
            hdr_idx_q  <= '0;
            cnt_q      <= '0;
            data_v_q   <= 1'b0;
            data_q     <= '0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (func_en) begin
            data_v_q <= 1'b0;
            data_q   <= '0;
            irq_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        if (tx_payload_len <= 16'd65515) begin
                            src_q      <= ip_addr;
                            dst_q      <= tx_dst_ip;
                            proto_q    <= tx_protocol;
                            len_q      <= tx_payload_len;
                            acc_q      <= '0;
                            calc_idx_q <= '0;
                            err_q      <= 1'b0;
                            state_q    <= S_CALC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    acc_q      <= acc_q + {4'd0, calc_word};
                    calc_idx_q <= calc_idx_q + 4'd1;
                    if (calc_idx_q == 4'd9)
                        state_q <= S_FOLD;
                end
                S_FOLD: begin
                    csum_q    <= csum_d;
                    hdr_idx_q <= '0;
                    state_q   <= S_HEADER;
                end
                S_HEADER: begin
                    data_v_q  <= 1'b1;
                    data_q    <= hdr_byte;
                    hdr_idx_q <= hdr_idx_q + 5'd1;
                    if (hdr_idx_q == 5'd19) begin
                        cnt_q <= '0;
                        if (len_q != 16'd0)
                            state_q <= S_PAYLOAD;
                        else
                            state_q <= pad_needed ? S_PAD : S_DONE;
                    end
                end
                S_PAYLOAD: begin
                    if (tx_payload_v) begin
                        data_v_q <= 1'b1;
                        data_q   <= tx_payload;
                        cnt_q    <= cnt_d;
                        if (cnt_d == len_q)
                            state_q <= pad_needed ? S_PAD : S_DONE;
                    end else begin
                        // Underrun: leave a gap, keep the frame going.
                        err_q <= 1'b1;
                    end
                end
                S_PAD: begin
                    // cnt_q continues from the payload count up to 26 total bytes.
                    data_v_q <= 1'b1;
                    cnt_q    <= cnt_d;
                    if (cnt_d == 16'd26)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    irq_q   <= 1'b1;
                    id_q    <= id_q + 16'd1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_busy        = (state_q != S_IDLE);
    assign tx_payload_rdy = func_en && (state_q == S_PAYLOAD);
    assign tx_ipv4_data_v = data_v_q;
    assign tx_ipv4_data   = data_q;
    assign tx_ipv4_irq    = irq_q;
    assign tx_ipv4_err    = err_q;

endmodule
